interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Consumes the one-cycle, 8-bit interrupt event pulses produced by the edge detector.
- Latches each event as pending and applies a software-writable enable mask.
- Arbitrates by fixed priority and runs a request/acknowledge/end-of-interrupt handshake with the CPU core.
- Sits between the edge detector and the core's interrupt entry logic; one interrupt is in service at a time, with no nesting.

Parameters:
- RESET_MASK, 8'h00, mask value loaded on reset. Default is all sources disabled.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- irqPulse  in  8  event pulses, one cycle wide per event; bit i is source i.
- maskWe  in  1  mask write enable.
- maskIn  in  8  new mask value; a 1 enables the source.
- intAck  in  1  CPU accepts the current request.
- intDone  in  1  CPU end-of-interrupt.
- intReq  out  1  interrupt request to the CPU.
- intVector  out  3  index of the requested or in-service source.
- inService  out  1  high while the CPU is servicing an interrupt.
- pendingOut  out  8  pending register, for status reads.
- maskOut  out  8  mask register.

Behaviour:
- All outputs are registered.
- Reset (synchronous, takes priority over everything):
  - pending=0, mask=RESET_MASK, state=IDLE.
  - intReq=0, intVector=0, inService=0.
  - irqPulse is ignored during the reset cycle.
  - Reset mid-handshake abandons the request or service with no further effect.
- Pending:
  - pending[i] is set on any edge where irqPulse[i]=1, regardless of mask. Masked events are held, not lost.
  - pending[i] is cleared only by an acknowledge of vector i.
  - Set beats clear: if irqPulse[i]=1 on the same edge that acknowledges i, pending[i] stays 1.
  - Repeated pulses on an already-pending bit collapse into one event.
- Mask:
  - maskWe=1 loads maskIn on that edge.
  - The new mask affects arbitration from the next cycle.
- Arbitration:
  - enabled = pending & mask, computed from registered values.
  - Bit 0 has the highest priority, bit 7 the lowest.
- FSM states:
  - IDLE:
    - intReq=0, inService=0.
    - If enabled!=0: go to REQ, latch intVector = index of the lowest set bit of enabled, and assert intReq.
  - REQ:
    - intReq=1. intVector is frozen; there is no re-arbitration, even if a higher-priority source arrives.
    - If intAck=1: clear pending[intVector], go to SERVICE, intReq=0, inService=1.
    - Else if mask[intVector]=0 (source masked while requesting): go to IDLE, intReq=0, pending kept.
    - intAck takes precedence over a simultaneous mask write that disables the source.
  - SERVICE:
    - inService=1, intVector held.
    - If intDone=1: go to IDLE, inService=0.
    - New pulses still latch into pending.
- Ignored inputs: intAck outside REQ, and intDone outside SERVICE.
- Latency:
  - A pulse sampled at edge N sets pending at N.
  - intReq is high after edge N+1, i.e. 2 cycles from pulse to request when the source is enabled and the FSM is IDLE.
  - After intDone at edge M, the next request can assert at edge M+1.
- intVector is valid whenever intReq or inService is 1; otherwise it holds its last value.
- pendingOut and maskOut mirror the registers directly.

Test Plan:
- Reset, then maskIn=8'hFF with maskWe; pulse irqPulse=8'h08 for 1 cycle -> pendingOut=8'h08 next cycle; intReq=1, intVector=3 two cycles after the pulse; intAck -> pendingOut=0, inService=1, intReq=0; intDone -> inService=0, state IDLE.
- Mask=8'hFF; pulse 8'h84 at once -> intVector=2 first; after ack and done, intReq reasserts with intVector=7; pendingOut ends at 0.
- Mask=8'h00; pulse 8'h01 -> pendingOut=8'h01, intReq stays 0; write mask=8'h01 -> intReq=1, intVector=0, 2 cycles after the write.
- In REQ with vector 5, clear mask bit 5 without intAck -> intReq=0 next cycle, pendingOut bit 5 still 1; re-enable it -> request reasserts with vector 5.
- Pulse bit 1 on the same edge as intAck for vector 1 -> pendingOut bit 1 remains 1; after intDone, a new request asserts with vector 1.
- Assert rst during SERVICE with pending=8'h30 -> next cycle all outputs 0, maskOut=RESET_MASK; stray intAck and intDone pulses afterwards cause no change.

Source files
------------

// File: rtl/interrupt_controller.sv
// Latches 8 interrupt event pulses as pending, masks them, and picks the lowest
// enabled index. It then runs a req/ack/done handshake with the CPU, one interrupt at a time.
module interrupt_controller #(
  parameter logic [7:0] RESET_MASK = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irqPulse,
  input  logic       maskWe,
  input  logic [7:0] maskIn,
  input  logic       intAck,
  input  logic       intDone,
  output logic       intReq,
  output logic [2:0] intVector,
  output logic       inService,
  output logic [7:0] pendingOut,
  output logic [7:0] maskOut
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] vec_q, vec_d;
  logic       req_q, req_d;
  logic       insvc_q, insvc_d;
  logic [7:0] enabled;

  // Bit 0 wins: scan downward so the last hit is the lowest index.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = i[2:0];
    end
    return r;
  endfunction

  assign enabled = pending_q & mask_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mask_d    = maskWe ? maskIn : mask_q;
    vec_d     = vec_q;
    req_d     = 1'b0;
    insvc_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|enabled) begin
          state_d = REQ;
          vec_d   = lowest_set(enabled);
          req_d   = 1'b1;
        end
      end
      REQ: begin
        // Vector stays frozen here; ack wins over the source being masked.
        if (intAck) begin
          pending_d[vec_q] = 1'b0;
          state_d          = SERVICE;
          insvc_d          = 1'b1;
        end else if (!mask_q[vec_q]) begin
          state_d = IDLE;
        end else begin
          req_d = 1'b1;
        end
      end
      SERVICE: begin
        if (intDone) begin
          state_d = IDLE;
        end else begin
          insvc_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new event on the acknowledged source re-arms it.
    pending_d = pending_d | irqPulse;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
      mask_q    <= RESET_MASK;
      vec_q     <= 3'd0;
      req_q     <= 1'b0;
      insvc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      vec_q     <= vec_d;
      req_q     <= req_d;
      insvc_q   <= insvc_d;
    end
  end

  assign intReq     = req_q;
  assign intVector  = vec_q;
  assign inService  = insvc_q;
  assign pendingOut = pending_q;
  assign maskOut    = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench: stimulus pushes expected (vector, cycle) for each request rise;
// a monitor pops and compares on every intReq rising, status is checked inline.
module tb_interrupt_controller;

  localparam logic [7:0] RM = 8'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irqPulse;
  logic       maskWe;
  logic [7:0] maskIn;
  logic       intAck;
  logic       intDone;
  logic       intReq;
  logic [2:0] intVector;
  logic       inService;
  logic [7:0] pendingOut;
  logic [7:0] maskOut;

  interrupt_controller #(.RESET_MASK(RM)) dut (
    .clk       (clk),
    .rst       (rst),
    .irqPulse  (irqPulse),
    .maskWe    (maskWe),
    .maskIn    (maskIn),
    .intAck    (intAck),
    .intDone   (intDone),
    .intReq    (intReq),
    .intVector (intVector),
    .inService (inService),
    .pendingOut(pendingOut),
    .maskOut   (maskOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] vec;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic prev_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising intReq must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1 && intReq === 1'b1 && !prev_req) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got vector %0d, expected no request (cycle %0d)", intVector, cyc);
      end else begin
        e = sb.pop_front();
        chk("req_vector", int'(intVector), int'(e.vec));
        chk("req_cycle", cyc, e.cyc);
      end
    end
    prev_req = (intReq === 1'b1);
  end

  task automatic nclk();
    @(negedge clk);
  endtask

  task automatic expect_req(input logic [2:0] v);
    exp_t e;
    e.vec = v;
    e.cyc = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic write_mask(input logic [7:0] m);
    maskWe = 1'b1;
    maskIn = m;
    nclk();
    maskWe = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] p);
    irqPulse = p;
    nclk();
    irqPulse = 8'h00;
  endtask

  task automatic do_ack();
    intAck = 1'b1;
    nclk();
    intAck = 1'b0;
  endtask

  task automatic do_done();
    intDone = 1'b1;
    nclk();
    intDone = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; irqPulse = 8'h00; maskWe = 1'b0; maskIn = 8'h00;
    intAck = 1'b0; intDone = 1'b0;
    nclk(); nclk();
    rst = 1'b0;
    chk("rst_req", int'(intReq), 0);
    chk("rst_insvc", int'(inService), 0);
    chk("rst_pending", int'(pendingOut), 0);
    chk("rst_mask", int'(maskOut), int'(RM));
    chk("rst_vec", int'(intVector), 0);

    // Single source, full handshake
    write_mask(8'hFF);
    chk("mask_ff", int'(maskOut), 8'hFF);
    expect_req(3'd3);
    pulse(8'h08);
    chk("t1_pending", int'(pendingOut), 8'h08);
    chk("t1_req_early", int'(intReq), 0);
    nclk();
    chk("t1_req", int'(intReq), 1);
    chk("t1_vec", int'(intVector), 3);
    do_ack();
    chk("t1_ack_pending", int'(pendingOut), 0);
    chk("t1_ack_insvc", int'(inService), 1);
    chk("t1_ack_req", int'(intReq), 0);
    do_done();
    chk("t1_done_insvc", int'(inService), 0);
    chk("t1_done_req", int'(intReq), 0);

    // Two sources at once: priority order
    expect_req(3'd2);
    pulse(8'h84);
    nclk();
    chk("t2_vec_first", int'(intVector), 2);
    do_ack();
    chk("t2_pending_mid", int'(pendingOut), 8'h80);
    expect_req(3'd7);
    do_done();
    nclk();
    chk("t2_vec_second", int'(intVector), 7);
    do_ack();
    do_done();
    chk("t2_pending_end", int'(pendingOut), 0);

    // Masked event is held, then released by a mask write
    write_mask(8'h00);
    pulse(8'h01);
    pulse(8'h01);
    chk("t3_pending", int'(pendingOut), 8'h01);
    nclk(); nclk();
    chk("t3_req_masked", int'(intReq), 0);
    expect_req(3'd0);
    write_mask(8'h01);
    nclk();
    chk("t3_req", int'(intReq), 1);
    chk("t3_vec", int'(intVector), 0);
    do_ack();
    do_done();
    chk("t3_pending_end", int'(pendingOut), 0);

    // Source masked while requesting
    write_mask(8'hFF);
    expect_req(3'd5);
    pulse(8'h20);
    nclk();
    write_mask(8'hDF);
    nclk();
    chk("t4_req_dropped", int'(intReq), 0);
    chk("t4_pending_kept", int'(pendingOut), 8'h20);
    expect_req(3'd5);
    write_mask(8'hFF);
    nclk();
    chk("t4_req_again", int'(intReq), 1);
    chk("t4_vec_again", int'(intVector), 5);
    do_ack();
    do_done();

    // Set beats clear on the acknowledge edge
    expect_req(3'd1);
    pulse(8'h02);
    nclk();
    irqPulse = 8'h02;
    do_ack();
    irqPulse = 8'h00;
    chk("t5_pending_kept", int'(pendingOut), 8'h02);
    chk("t5_insvc", int'(inService), 1);
    expect_req(3'd1);
    do_done();
    nclk();
    chk("t5_vec_again", int'(intVector), 1);
    do_ack();
    do_done();

    // Reset during service
    expect_req(3'd0);
    pulse(8'h31);
    nclk();
    do_ack();
    chk("t6_pending", int'(pendingOut), 8'h30);
    chk("t6_insvc", int'(inService), 1);
    rst = 1'b1;
    nclk();
    rst = 1'b0;
    chk("t6_rst_pending", int'(pendingOut), 0);
    chk("t6_rst_insvc", int'(inService), 0);
    chk("t6_rst_req", int'(intReq), 0);
    chk("t6_rst_vec", int'(intVector), 0);
    chk("t6_rst_mask", int'(maskOut), int'(RM));
    do_ack();
    do_done();
    nclk(); nclk();
    chk("t6_stray_req", int'(intReq), 0);
    chk("t6_stray_insvc", int'(inService), 0);
    chk("t6_stray_pending", int'(pendingOut), 0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
